// File: rtl/dsa_pkg.sv
// dsa_pkg: shared definitions for the digit-serial adder.
//   state_t   - controller states (IDLE, RUN, DONE)
//   DIGIT_W   - bits processed per step by the adder slice
//   cnt_width - digit counter width for a given operand width (minimum 1)
package dsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DIGIT_W = 2;

  // clog2 of the digit count; a single-digit operand still needs a 1-bit counter
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width / DIGIT_W);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/digit_add_2bit.sv
// digit_add_2bit: combinational 2-bit adder slice.
// Ports:
//   a[1:0], b[1:0] - digit operands
//   cin            - carry in
//   s[1:0]         - digit sum
//   cout           - carry out
module digit_add_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic [2:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {2'b00, cin};
  assign s       = total_s[1:0];
  assign cout    = total_s[2];

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands two bits per cycle,
// least-significant digit first, using one digit_add_2bit slice and a
// carry register, wrapped in a start/busy/done handshake.
// Optional feature macro: DSA_OVERFLOW_EN adds the signed overflow output.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset; aborts any operation
//   start    - request, honoured only in IDLE
//   a, b     - operands, captured on the accepting edge
//   busy     - high while digits are processed (RUN)
//   done     - one-cycle completion pulse
//   sum      - A+B mod 2^WIDTH, held until the next completion
//   carry    - unsigned carry out of the MSB, held with sum
//   overflow - two's complement overflow (DSA_OVERFLOW_EN only)
module digit_serial_adder
  import dsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef DSA_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             carry
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(WIDTH / DIGIT_W - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cin_r;
  logic [1:0]       slice_s;
  logic             slice_cout_s;
  logic             last_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
`ifdef DSA_OVERFLOW_EN
  logic             msb_cin_s;
  logic             overflow_r;
`endif

  digit_add_2bit u_slice (
    .a    (opa_r[1:0]),
    .b    (opb_r[1:0]),
    .cin  (cin_r),
    .s    (slice_s),
    .cout (slice_cout_s)
  );

  assign last_s = (cnt_r == LAST_DIGIT);

`ifdef DSA_OVERFLOW_EN
  // Carry into the MSB is recovered from the top sum bit of the final digit.
  assign msb_cin_s = slice_s[1] ^ opa_r[1] ^ opb_r[1];
`endif

  // Result register shifts right; the new digit enters at the MSB end.
  always_comb begin
    res_next_s = res_r >> DIGIT_W;
    res_next_s[WIDTH-1 -: 2] = slice_s;
  end

  // Next-state logic for the controller.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == RUN);
      done_r  <= (next_state_s == DONE);
    end
  end

  // Operand shift registers, carry register, digit counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      cin_r   <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            opa_r <= a;
            opb_r <= b;
            cnt_r <= {CNT_W{1'b0}};
            cin_r <= 1'b0;
          end
        end
        RUN: begin
          opa_r <= opa_r >> DIGIT_W;
          opb_r <= opb_r >> DIGIT_W;
          res_r <= res_next_s;
          cin_r <= slice_cout_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_s) begin
            sum_r   <= res_next_s;
            carry_r <= slice_cout_s;
          end
        end
        DONE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
          cin_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef DSA_OVERFLOW_EN
  // Signed overflow captured alongside sum and carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if ((state_r == RUN) && last_s) begin
      overflow_r <= msb_cin_s ^ slice_cout_s;
    end
  end

  assign overflow = overflow_r;
`endif

  assign busy  = busy_r;
  assign done  = done_r;
  assign sum   = sum_r;
  assign carry = carry_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
module tb_digit_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;
`ifdef DSA_OVERFLOW_EN
  logic       overflow;
`endif

  int passed = 0;
  int total  = 0;

  digit_serial_adder #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
`ifdef DSA_OVERFLOW_EN
    .overflow (overflow),
`endif
    .carry    (carry)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned 9-bit addition.
  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Reference: two's complement overflow from operand and result signs.
  function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    r = x + y;
    return (x[7] == y[7]) && (r[7] != x[7]);
  endfunction

  // Runs one operation; called at a negedge with the DUT idle. Returns
  // observations only. Optionally pulses start with FF/FF during busy.
  task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input bit pulse,
                       output int busy_cnt, output int done_cnt, output int done_idx,
                       output int overlap, output logic [7:0] s_obs,
                       output logic c_obs, output logic o_obs);
    busy_cnt = 0; done_cnt = 0; done_idx = -1; overlap = 0;
    s_obs = 8'h00; c_obs = 1'b0; o_obs = 1'b0;
    start = 1'b1; a = xa; b = xb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx = i;
          s_obs = sum;
          c_obs = carry;
`ifdef DSA_OVERFLOW_EN
          o_obs = overflow;
`endif
        end
      end
      if (pulse && i == 1) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end else begin
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; a = 8'h5A; b = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL reset_busy cyc%0d got %b want 0", i, busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done cyc%0d got %b want 0", i, done); else passed++;
      total++; if (sum !== 8'h00) $display("FAIL reset_sum cyc%0d got %h want 00", i, sum); else passed++;
      total++; if (carry !== 1'b0) $display("FAIL reset_carry cyc%0d got %b want 0", i, carry); else passed++;
    end
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_nocapture busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_op(input string name, input logic [7:0] xa, input logic [7:0] xb, input bit pulse);
    int bc, dc, di, ov;
    logic [7:0] s;
    logic c, o;
    logic [8:0] exp;
    exp = ref_add(xa, xb);
    do_op(xa, xb, pulse, bc, dc, di, ov, s, c, o);
    total++; if (bc !== 4) $display("FAIL %s_busy_cycles got %0d want 4", name, bc); else passed++;
    total++; if (dc !== 1) $display("FAIL %s_done_count got %0d want 1", name, dc); else passed++;
    total++; if (di !== 4) $display("FAIL %s_done_latency got %0d want 4", name, di); else passed++;
    total++; if (ov !== 0) $display("FAIL %s_busy_done_overlap got %0d want 0", name, ov); else passed++;
    total++; if (s !== exp[7:0]) $display("FAIL %s_sum got %h want %h", name, s, exp[7:0]); else passed++;
    total++; if (c !== exp[8]) $display("FAIL %s_carry got %b want %b", name, c, exp[8]); else passed++;
`ifdef DSA_OVERFLOW_EN
    total++; if (o !== ref_ovf(xa, xb)) $display("FAIL %s_overflow got %b want %b", name, o, ref_ovf(xa, xb)); else passed++;
`endif
    // result must hold after completion
    total++; if (sum !== exp[7:0]) $display("FAIL %s_sum_hold got %h want %h", name, sum, exp[7:0]); else passed++;
  endtask

  task automatic test_directed();
    test_op("zero", 8'h00, 8'h00, 1'b0);
    test_op("wrap", 8'hFF, 8'h01, 1'b0);
    test_op("ovf_pos", 8'h7F, 8'h01, 1'b0);
    test_op("ovf_neg", 8'h80, 8'h80, 1'b0);
  endtask

  task automatic test_start_ignored();
    test_op("ignore_start", 8'h12, 8'h34, 1'b1);
  endtask

  task automatic test_reset_abort();
    int dcnt;
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL abort_busy_started got %b want 1", busy); else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else passed++;
    total++; if (sum !== 8'h00) $display("FAIL abort_sum got %h want 00", sum); else passed++;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) dcnt++;
      @(negedge clk);
    end
    total++; if (dcnt !== 0) $display("FAIL abort_no_done got %0d active cycles want 0", dcnt); else passed++;
    test_op("after_abort", 8'hAA, 8'h55, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] xa, xb;
    for (int k = 0; k < 20; k++) begin
      xa = 8'($urandom); xb = 8'($urandom);
      test_op($sformatf("rand%0d", k), xa, xb, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [18];
    logic [7:0] pb [18];
    logic [8:0] exp;
    bit want;
    for (int i = 0; i < 18; i++) begin
      pa[i] = 8'($urandom); pb[i] = 8'($urandom);
    end
    start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      a = pa[i]; b = pb[i];
      @(posedge clk);
      @(negedge clk);
      // accepts at cycles 0, 6, 12 -> completion four cycles later
      want = (i % 6) == 4;
      total++; if (done !== want) $display("FAIL b2b_done cyc%0d got %b want %b", i, done, want); else passed++;
      if (want) begin
        exp = ref_add(pa[i-4], pb[i-4]);
        total++; if ({carry, sum} !== exp) $display("FAIL b2b_result cyc%0d got %h want %h", i, {carry, sum}, exp); else passed++;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    @(negedge clk);
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
